// File: rtl/step_drv_if.sv
// Handshake and control bundle between the pulse controller and the STEP/DIR output stage.
// The slave modport is the step_drv side; master is the controller side.
interface step_drv_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned POS_W = 32
) ();
    logic             abort;
    logic             pls;
    logic             dir;
    logic [CNT_W-1:0] t_setup;
    logic [CNT_W-1:0] t_width;
    logic [CNT_W-1:0] t_low;
    logic             pos_clr;
    logic             pos_ld;
    logic [POS_W-1:0] pos_in;
    logic             err_clr;
    logic             step_o;
    logic             dir_o;
    logic             busy;
    logic             err_ovr;
    logic [POS_W-1:0] pos;

    modport master (
        output abort, pls, dir, t_setup, t_width, t_low,
        output pos_clr, pos_ld, pos_in, err_clr,
        input  step_o, dir_o, busy, err_ovr, pos
    );

    modport slave (
        input  abort, pls, dir, t_setup, t_width, t_low,
        input  pos_clr, pos_ld, pos_in, err_clr,
        output step_o, dir_o, busy, err_ovr, pos
    );
endinterface

// File: rtl/step_drv.sv
// STEP/DIR output stage: shapes single-cycle step strobes into timed STEP/DIR waveforms,
// tracks signed position and buffers one early request, flagging overruns.
module step_drv #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned POS_W = 32
) (
    input  logic        clk,
    input  logic        aclr_n,
    step_drv_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pend_q, pend_d;
    logic             pend_dir_q, pend_dir_d;

    logic pls_v, req, req_dir, phase_end, service, enter_high;

    // Phase lasts max(t,1) cycles: counter runs down to zero.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        err_d      = err_q & ~bus.err_clr;
        pos_d      = pos_q;
        service    = 1'b0;
        enter_high = 1'b0;

        pls_v     = bus.pls & ~bus.abort;
        req       = pend_q | pls_v;
        req_dir   = pend_q ? pend_dir_q : bus.dir;
        phase_end = (cnt_q == '0);

        unique case (state_q)
            IDLE: service = req;
            SETUP: begin
                if (phase_end) enter_high = 1'b1;
                else           cnt_d = cnt_q - CNT_W'(1);
            end
            HIGH: begin
                if (phase_end) begin
                    step_d  = 1'b0;
                    state_d = LOW;
                    cnt_d   = phase_load(bus.t_low);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (phase_end) begin
                    if (req) service = 1'b1;
                    else     state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (service) begin
            pend_d = 1'b0;
            if (req_dir != dir_q) begin
                dir_d   = req_dir;
                state_d = SETUP;
                cnt_d   = phase_load(bus.t_setup);
            end else begin
                enter_high = 1'b1;
            end
        end

        if (enter_high) begin
            state_d = HIGH;
            step_d  = 1'b1;
            cnt_d   = phase_load(bus.t_width);
        end

        // A strobe not consumed directly lands in the slot; a pending request served
        // this cycle frees the slot so a coincident strobe refills it.
        if (pls_v && !(service && !pend_q)) begin
            if (pend_d) begin
                err_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_dir_d = bus.dir;
            end
        end

        if (bus.abort) begin
            state_d    = IDLE;
            step_d     = 1'b0;
            pend_d     = 1'b0;
            dir_d      = dir_q;
            enter_high = 1'b0;
        end

        if (bus.pos_clr)     pos_d = '0;
        else if (bus.pos_ld) pos_d = bus.pos_in;
        else if (enter_high) pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

        busy_d = (state_d != IDLE) | pend_d;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
        end
    end

    assign bus.step_o  = step_q;
    assign bus.dir_o   = dir_q;
    assign bus.busy    = busy_q;
    assign bus.err_ovr = err_q;
    assign bus.pos     = pos_q;

endmodule

// File: tb/tb_step_drv.sv
// Directed bench for step_drv: expected STEP pulses are queued as they are requested and
// a monitor compares each emitted pulse (rise cycle, width, position, direction).
module tb_step_drv;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned rise;
        int unsigned width;
        logic [31:0] pos;
        logic        dir;
    } exp_t;

    exp_t expq[$];

    step_drv_if #(.CNT_W(16), .POS_W(32)) bus ();

    step_drv #(.CNT_W(16), .POS_W(32)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_step(input int unsigned rise, input int unsigned width,
                               input logic [31:0] pos, input logic dir);
        exp_t e;
        e.rise = rise; e.width = width; e.pos = pos; e.dir = dir;
        expq.push_back(e);
    endtask

    // Advance to #1 after the edge that starts cycle c.
    task automatic step_to(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_at(input int unsigned c, input logic d);
        step_to(c);
        bus.pls = 1'b1;
        bus.dir = d;
        step_to(c + 1);
        bus.pls = 1'b0;
    endtask

    // Monitor: one comparison set per completed STEP pulse.
    logic        prev_step = 1'b0;
    int unsigned m_rise, m_width;
    logic [31:0] m_pos;
    logic        m_dir;
    always @(negedge clk) begin
        if (!aclr_n) begin
            prev_step = 1'b0;
        end else begin
            if (bus.step_o && !prev_step) begin
                m_rise  = cyc;
                m_width = 1;
                m_pos   = bus.pos;
                m_dir   = bus.dir_o;
            end else if (bus.step_o) begin
                m_width++;
            end else if (prev_step) begin
                if (expq.size() == 0) begin
                    check("unexpected_step", 64'(m_rise), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("step_rise_cycle", 64'(m_rise), 64'(e.rise));
                    check("step_width", 64'(m_width), 64'(e.width));
                    check("step_pos", 64'(m_pos), 64'(e.pos));
                    check("step_dir", 64'(m_dir), 64'(e.dir));
                end
            end
            prev_step = bus.step_o;
        end
    end

    int unsigned c;
    initial begin
        bus.abort = 0; bus.pls = 0; bus.dir = 0;
        bus.t_setup = 0; bus.t_width = 0; bus.t_low = 0;
        bus.pos_clr = 0; bus.pos_ld = 0; bus.pos_in = '0; bus.err_clr = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_step", 64'(bus.step_o), 0);
        check("rst_dir", 64'(bus.dir_o), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_err", 64'(bus.err_ovr), 0);
        check("rst_pos", 64'(bus.pos), 0);
        aclr_n = 1'b1;

        // First positive step after reset changes direction: SETUP of 1 cycle.
        bus.t_setup = 0; bus.t_width = 3; bus.t_low = 2;
        c = cyc + 2;
        expect_step(c + 2, 3, 32'd1, 1'b1);
        pulse_at(c, 1'b1);
        check("t1_dir_rise", 64'(bus.dir_o), 1);
        step_to(c + 6);  check("t1_busy_hi", 64'(bus.busy), 1);
        step_to(c + 7);  check("t1_busy_lo", 64'(bus.busy), 0);

        // Same direction: step at k+1, busy low 6 cycles after pls.
        c = cyc + 2;
        expect_step(c + 1, 3, 32'd2, 1'b1);
        pulse_at(c, 1'b1);
        step_to(c + 5);  check("t2_busy_hi", 64'(bus.busy), 1);
        step_to(c + 6);  check("t2_busy_lo", 64'(bus.busy), 0);

        // Direction change with 4-cycle setup.
        bus.t_setup = 4;
        c = cyc + 2;
        step_to(c);      check("t3_dir_before", 64'(bus.dir_o), 1);
        expect_step(c + 5, 3, 32'd1, 1'b0);
        pulse_at(c, 1'b0);
        check("t3_dir_fall", 64'(bus.dir_o), 0);
        step_to(c + 9);  check("t3_busy_hi", 64'(bus.busy), 1);
        step_to(c + 10); check("t3_busy_lo", 64'(bus.busy), 0);

        // Back-to-back through the pending slot: period 5.
        bus.t_setup = 1;
        c = cyc + 2;
        expect_step(c + 1,  3, 32'd0,          1'b0);
        expect_step(c + 6,  3, 32'hFFFF_FFFF,  1'b0);
        expect_step(c + 11, 3, 32'hFFFF_FFFE,  1'b0);
        pulse_at(c, 1'b0);
        pulse_at(c + 3, 1'b0);
        pulse_at(c + 9, 1'b0);
        step_to(c + 20);
        check("cont_err", 64'(bus.err_ovr), 0);
        check("cont_busy", 64'(bus.busy), 0);

        // Three strobes inside one step: one pending, one dropped.
        c = cyc + 2;
        expect_step(c + 1, 3, 32'hFFFF_FFFD, 1'b0);
        expect_step(c + 6, 3, 32'hFFFF_FFFC, 1'b0);
        pulse_at(c, 1'b0);
        pulse_at(c + 1, 1'b0);
        pulse_at(c + 2, 1'b0);
        step_to(c + 3);  check("ovr_set", 64'(bus.err_ovr), 1);
        step_to(c + 15); check("ovr_sticky", 64'(bus.err_ovr), 1);
        bus.err_clr = 1'b1;
        step_to(c + 16); bus.err_clr = 1'b0;
        check("ovr_clr", 64'(bus.err_ovr), 0);

        // Load near the positive limit, then wrap on a positive step.
        c = cyc + 1;
        step_to(c);
        bus.pos_in = 32'h7FFF_FFFF; bus.pos_ld = 1'b1;
        step_to(c + 1);  bus.pos_ld = 1'b0;
        check("pos_load", 64'(bus.pos), 64'h7FFF_FFFF);
        c = cyc + 1;
        expect_step(c + 2, 3, 32'h8000_0000, 1'b1);
        pulse_at(c, 1'b1);
        step_to(c + 8);  check("pos_wrap", 64'(bus.pos), 64'h8000_0000);
        bus.pos_clr = 1'b1; bus.pos_ld = 1'b1; bus.pos_in = 32'h1234;
        step_to(c + 9);  bus.pos_clr = 1'b0; bus.pos_ld = 1'b0;
        check("pos_clr_prio", 64'(bus.pos), 0);

        // Abort mid-HIGH with a request pending; pls during abort is ignored.
        bus.t_width = 5;
        c = cyc + 2;
        expect_step(c + 1, 2, 32'd1, 1'b1);
        pulse_at(c, 1'b1);
        pulse_at(c + 1, 1'b1);
        bus.abort = 1'b1; bus.pls = 1'b1;
        step_to(c + 3);  bus.abort = 1'b0; bus.pls = 1'b0;
        check("abort_step", 64'(bus.step_o), 0);
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_pos", 64'(bus.pos), 1);
        check("abort_dir", 64'(bus.dir_o), 1);
        step_to(c + 20);
        check("abort_no_more", 64'(bus.pos), 1);

        // All timings zero behave as one: period 2.
        bus.t_setup = 0; bus.t_width = 0; bus.t_low = 0;
        c = cyc + 2;
        expect_step(c + 1, 1, 32'd2, 1'b1);
        expect_step(c + 3, 1, 32'd3, 1'b1);
        expect_step(c + 5, 1, 32'd4, 1'b1);
        pulse_at(c, 1'b1);
        pulse_at(c + 2, 1'b1);
        pulse_at(c + 4, 1'b1);
        step_to(c + 10);
        check("zero_err", 64'(bus.err_ovr), 0);
        check("zero_pos", 64'(bus.pos), 4);

        c = cyc + 200;
        while (expq.size() != 0 && cyc < c) step_to(cyc + 1);
        check("scoreboard_drained", 64'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
